// File: rtl/writeback_regfile_pkg.sv
// Shared y86 constants: status codes, icodes, register IDs and the W-stage
// register layout used by the fetch, decode and writeback stages.
package writeback_regfile_pkg;

  typedef enum logic [3:0] {
    STAT_AOK = 4'h1,
    STAT_HLT = 4'h2,
    STAT_ADR = 4'h3,
    STAT_INS = 4'h4
  } statE;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE    = 4'hF;
  localparam int         REG_RSP  = 4;
  localparam int         NUM_REGS = 15;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  destE;
    logic [3:0]  destM;
  } wRegT;

  // Contents of W after a bubble or reset: an AOK nop that writes nothing.
  localparam wRegT W_BUBBLE = '{
    stat:  STAT_AOK,
    icode: I_NOP,
    valE:  64'h0,
    valM:  64'h0,
    destE: RNONE,
    destM: RNONE
  };

endpackage

// File: rtl/writeback_regfile_if.sv
// Memory-to-writeback pipeline bus: M-stage results and W control in,
// W register contents out (these also feed decode forwarding).
interface writeback_regfile_if;
  logic [3:0]  M_stat;
  logic [3:0]  M_icode;
  logic [63:0] M_valE;
  logic [63:0] m_valM;
  logic [3:0]  M_destE;
  logic [3:0]  M_destM;
  logic        W_stall;
  logic        W_bubble;
  logic [3:0]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  W_destE;
  logic [3:0]  W_destM;

  modport master (
    output M_stat, M_icode, M_valE, m_valM, M_destE, M_destM, W_stall, W_bubble,
    input  W_stat, W_icode, W_valE, W_valM, W_destE, W_destM
  );

  modport slave (
    input  M_stat, M_icode, M_valE, m_valM, M_destE, M_destM, W_stall, W_bubble,
    output W_stat, W_icode, W_valE, W_valM, W_destE, W_destM
  );
endinterface

// File: rtl/writeback_regfile_regfile_2w.sv
// Architectural register file: 15 x 64-bit, two write ports (E and M),
// all registers exposed in parallel. M wins when both ports hit one register.
module regfile_2w
  import writeback_regfile_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrE,
  input  logic [3:0]  dstE,
  input  logic [63:0] valE,
  input  logic        wrM,
  input  logic [3:0]  dstM,
  input  logic [63:0] valM,
  output logic [63:0] regs [NUM_REGS]
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the register file is reset on purpose -- software relies on
      // zeroed registers and a defined stack pointer; plain RAMs usually are not.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == REG_RSP) ? RSP_INIT : 64'h0;
      end
    end else begin
      // ID 4'hF matches no entry, so writes to RNONE fall away naturally.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wrE && dstE == 4'(i)) regs[i] <= valE;
        // Later non-blocking assignment wins: gives the M port priority.
        if (wrM && dstM == 4'(i)) regs[i] <= valM;
      end
    end
  end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: W pipeline register, halt latch, retired counter, and the
// two-port register file commit of the instruction sitting in W.
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int          CNT_W    = 32,
  parameter logic [63:0] RSP_INIT = 64'h0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  writeback_regfile_if.slave   wb,
  output logic [63:0]          reg0,
  output logic [63:0]          reg1,
  output logic [63:0]          reg2,
  output logic [63:0]          reg3,
  output logic [63:0]          reg4,
  output logic [63:0]          reg5,
  output logic [63:0]          reg6,
  output logic [63:0]          reg7,
  output logic [63:0]          reg8,
  output logic [63:0]          reg9,
  output logic [63:0]          reg10,
  output logic [63:0]          reg11,
  output logic [63:0]          reg12,
  output logic [63:0]          reg13,
  output logic [63:0]          reg14,
  output logic [3:0]           prog_stat,
  output logic                 halted,
  output logic [CNT_W-1:0]     retired
);

  wRegT        wReg;
  wRegT        wLoad;
  logic        wValid;
  logic        commitOk;
  logic        wrE;
  logic        wrM;
  logic [63:0] regView [NUM_REGS];

  assign wLoad = '{
    stat:  wb.M_stat,
    icode: wb.M_icode,
    valE:  wb.M_valE,
    valM:  wb.m_valM,
    destE: wb.M_destE,
    destM: wb.M_destM
  };

  always_comb begin
    // NOTE: every always_comb output gets a value on every path before any
    // condition, otherwise synthesis infers a latch.
    commitOk = 1'b0;
    wrE      = 1'b0;
    wrM      = 1'b0;
    if (!halted && wReg.stat == STAT_AOK) begin
      commitOk = 1'b1;
      wrE      = (wReg.destE != RNONE);
      wrM      = (wReg.destM != RNONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      wReg      <= W_BUBBLE;
      wValid    <= 1'b0;
      halted    <= 1'b0;
      prog_stat <= STAT_AOK;
      retired   <= '0;
    end else begin
      if (!wb.W_stall) begin
        wReg   <= wb.W_bubble ? W_BUBBLE : wLoad;
        wValid <= !wb.W_bubble;
      end
      if (!halted && wReg.stat != STAT_AOK) begin
        halted    <= 1'b1;
        prog_stat <= wReg.stat;
      end
      // A stalled instruction commits every cycle but counts only as it leaves.
      if (commitOk && wValid && !wb.W_stall) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

  regfile_2w #(
    .RSP_INIT (RSP_INIT)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .wrE   (wrE),
    .dstE  (wReg.destE),
    .valE  (wReg.valE),
    .wrM   (wrM),
    .dstM  (wReg.destM),
    .valM  (wReg.valM),
    .regs  (regView)
  );

  assign wb.W_stat  = wReg.stat;
  assign wb.W_icode = wReg.icode;
  assign wb.W_valE  = wReg.valE;
  assign wb.W_valM  = wReg.valM;
  assign wb.W_destE = wReg.destE;
  assign wb.W_destM = wReg.destM;

  assign reg0  = regView[0];
  assign reg1  = regView[1];
  assign reg2  = regView[2];
  assign reg3  = regView[3];
  assign reg4  = regView[4];
  assign reg5  = regView[5];
  assign reg6  = regView[6];
  assign reg7  = regView[7];
  assign reg8  = regView[8];
  assign reg9  = regView[9];
  assign reg10 = regView[10];
  assign reg11 = regView[11];
  assign reg12 = regView[12];
  assign reg13 = regView[13];
  assign reg14 = regView[14];

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 Parameter RSP_INIT, default 64'h0: reset value of reg4 (%rsp).
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst_n  in  1  synchronous, active-low reset; sampled on posedge clk.
REQ-005 M_stat  in  4  memory-stage status (AOK=1, HLT=2, ADR=3, INS=4).
REQ-006 M_icode  in  4  memory-stage icode.
REQ-007 M_valE  in  64  memory-stage ALU result.
REQ-008 m_valM  in  64  data read from memory this cycle.
REQ-009 M_destE, M_destM  in  4 each  destination register IDs; 4'hF = none.
REQ-010 W_stall, W_bubble  in  1 each  pipeline control for the W register.
REQ-011 W_stat, W_icode  out  4 each  W register contents.
REQ-012 W_valE, W_valM  out  64 each  W register contents, fed to decode forwarding.
REQ-013 W_destE, W_destM  out  4 each  W register contents, fed to decode forwarding.
REQ-014 reg0 .. reg14  out  64 each  architectural register file contents.
REQ-015 prog_stat  out  4  program status: AOK while running, else first non-AOK W_stat.
REQ-016 halted  out  1  high once a non-AOK status has reached W.
REQ-017 retired  out  CNT_W  count of instructions committed.

Function
REQ-018 W register SHALL load {M_stat, M_icode, M_valE, m_valM, M_destE, M_destM} on posedge when W_stall=0 and W_bubble=0.
REQ-019 W_stall=1 SHALL hold all W register fields; stall has priority over W_bubble.
REQ-020 W_bubble=1 (with W_stall=0) SHALL load stat=AOK, icode=NOP (4'h1), destE=destM=4'hF, valE=valM=0, and clear an internal W_valid bit; a normal load sets W_valid=1.
REQ-021 On each posedge with halted=0 and W_stat=AOK, W_destE!=4'hF SHALL write W_valE into reg[W_destE].
REQ-022 Under the same condition, W_destM!=4'hF SHALL write W_valM into reg[W_destM].
REQ-023 If W_destE==W_destM!=4'hF, the M write SHALL win (popq %rsp semantics).
REQ-024 Register writes SHALL become visible on reg* outputs one cycle after the instruction occupies W; same-cycle visibility is provided by decode forwarding from the W_* outputs, not by this block.
REQ-025 When W_stat!=AOK and halted=0, the block SHALL set halted=1 and latch prog_stat=W_stat on that posedge; that instruction SHALL perform no register write.
REQ-026 Once halted=1, all register writes and counter increments SHALL be suppressed, and prog_stat SHALL hold until reset; the W register keeps obeying stall and bubble.
REQ-027 retired SHALL increment by 1 on each posedge where W_valid=1, W_stat=AOK, W_stall=0 and halted=0; a stalled instruction counts once, when it leaves W.
REQ-028 retired SHALL wrap modulo 2^CNT_W.
REQ-029 Writes to register ID 4'hF SHALL be ignored; IDs 0..14 are all writable.

Reset
REQ-030 rst_n=0 at posedge SHALL clear reg0..reg14 to 0, except reg4=RSP_INIT.
REQ-031 Reset SHALL also set the W register to the bubble value with W_valid=0, prog_stat=AOK, halted=0, retired=0.
REQ-032 Reset SHALL override stall, bubble and any pending write in the same cycle, including a halt arriving mid-operation.

Structure
REQ-033 Stat codes (AOK/HLT/ADR/INS), icode constants (NOP etc.) and RNONE=4'hF SHALL live in a shared y86 constants package used with the decode and fetch stages.
REQ-034 The register array SHALL be a sub-module regfile_2w (two write ports, M priority, 15 parallel read outputs); W register, halt latch and counter stay in the top.

Verification
REQ-035 Reset with RSP_INIT=64'h100 -> reg4=64'h100, all other regs 0, prog_stat=1, halted=0, retired=0.
REQ-036 Load irmovq (M_destE=3, M_valE=64'h2A, M_destM=F) -> next cycle W_destE=3; one cycle later reg3=64'h2A and retired=1.
REQ-037 Load popq %rsp (M_destE=4, M_valE=64'h108, M_destM=4, m_valM=64'hDEAD) -> reg4=64'hDEAD.
REQ-038 Hold W_stall=1 for 3 cycles with W_destE=5 -> reg5 written each cycle with the same value and retired increments once, after release; W_bubble=1 -> W_destE=F, W_icode=1 and retired unchanged.
REQ-039 M_stat=ADR with M_destE=2 reaches W -> reg2 unchanged, halted=1, prog_stat=3; later AOK writes are ignored and retired is frozen.
REQ-040 With CNT_W=4, retire 17 instructions -> retired=1; assert rst_n=0 while halted -> everything returns to the REQ-030/031 values.
